// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: two-requester round-robin arbiter that expands whole
// write/read transactions into the SPI RAM 10-bit opcode stream
// (00 wr_addr, 01 write, 10 rd_addr, 11 read) and returns read data.
// Optional feature macro: RAM_ADDR_CACHE_EN. When defined, the last write and
// read addresses sent to the RAM are remembered, and a repeated address skips
// its address command.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [2*ADDR_SIZE-1:0] addr,
  input  logic [15:0]            wdata,
  output logic [1:0]             ack,
  output logic [7:0]             rdata,
  output logic                   rd_valid,
  output logic                   rd_err,
  output logic [9:0]             ram_din,
  output logic                   ram_rx_valid,
  input  logic [7:0]             ram_dout,
  input  logic                   ram_tx_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;

  logic [1:0]           ack_q, ack_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_err_q, rd_err_d;
  logic [9:0]           ram_din_q, ram_din_d;
  logic                 rx_valid_q, rx_valid_d;

  // Grant selection. A requester whose ack is on the wire this cycle is
  // ignored: it only counts as a new request if still high the cycle after.
  logic [1:0]           req_eff;
  logic                 winner;
  logic                 we_sel;
  logic [ADDR_SIZE-1:0] addr_sel;
  logic [7:0]           wdata_sel;
  logic                 wr_hit, rd_hit;

  assign req_eff   = req & ~ack_q;
  assign winner    = (req_eff == 2'b11) ? rr_q : req_eff[1];
  assign we_sel    = we[winner];
  assign addr_sel  = winner ? addr[2*ADDR_SIZE-1:ADDR_SIZE] : addr[ADDR_SIZE-1:0];
  assign wdata_sel = winner ? wdata[15:8] : wdata[7:0];

`ifdef RAM_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] wc_addr_q, wc_addr_d, rc_addr_q, rc_addr_d;
  logic                 wc_vld_q, wc_vld_d, rc_vld_q, rc_vld_d;

  assign wr_hit = wc_vld_q && (wc_addr_q == addr_sel);
  assign rd_hit = rc_vld_q && (rc_addr_q == addr_sel);

  // Address cache: remembers what the RAM address registers currently hold
  always_comb begin
    wc_addr_d = wc_addr_q;
    wc_vld_d  = wc_vld_q;
    rc_addr_d = rc_addr_q;
    rc_vld_d  = rc_vld_q;
    if (state_d == WR_ADDR) begin
      wc_addr_d = addr_d;
      wc_vld_d  = 1'b1;
    end
    if (state_d == RD_ADDR) begin
      rc_addr_d = addr_d;
      rc_vld_d  = 1'b1;
    end
  end

  // Cache valid bits are cleared on reset; cached addresses need no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wc_vld_q <= 1'b0;
      rc_vld_q <= 1'b0;
    end else begin
      wc_vld_q <= wc_vld_d;
      rc_vld_q <= rc_vld_d;
    end
    wc_addr_q <= wc_addr_d;
    rc_addr_q <= rc_addr_d;
  end
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif

  // State register plus registered outputs (all reset to zero)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 2'b00;
      rdata_q    <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      ram_din_q  <= 10'h000;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      ram_din_q  <= ram_din_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Latched transaction fields; only meaningful once a grant has loaded them
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Next-state logic: grant in IDLE, walk the opcode sequence, time out reads
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (|req_eff) begin
          owner_d = winner;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          rr_d    = ~winner;
          cnt_d   = '0;
          if (we_sel) state_d = wr_hit ? WR_DATA : WR_ADDR;
          else        state_d = rd_hit ? RD_CMD  : RD_ADDR;
        end
      end
      WR_ADDR: state_d = WR_DATA;
      WR_DATA: state_d = IDLE;
      RD_ADDR: state_d = RD_CMD;
      RD_CMD: begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        if (ram_tx_valid || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: outputs are loaded for the state being entered so that the
  // registered command appears in the same cycle the FSM occupies that state
  always_comb begin
    ack_d      = 2'b00;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    rdata_d    = rdata_q;
    ram_din_d  = ram_din_q;
    rx_valid_d = 1'b0;
    case (state_d)
      WR_ADDR: begin
        ram_din_d  = {2'b00, 8'(addr_d)};
        rx_valid_d = 1'b1;
      end
      WR_DATA: begin
        ram_din_d       = {2'b01, wdata_d};
        rx_valid_d      = 1'b1;
        ack_d[owner_d]  = 1'b1;
      end
      RD_ADDR: begin
        ram_din_d  = {2'b10, 8'(addr_d)};
        rx_valid_d = 1'b1;
      end
      RD_CMD: begin
        ram_din_d  = {2'b11, 8'h00};
        rx_valid_d = 1'b1;
      end
      IDLE: begin
        if (state_q == RD_WAIT) begin
          ack_d[owner_q] = 1'b1;
          if (ram_tx_valid) begin
            rdata_d    = ram_dout;
            rd_valid_d = 1'b1;
          end else begin
            rdata_d  = 8'h00;
            rd_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign rd_valid     = rd_valid_q;
  assign rd_err       = rd_err_q;
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed testbench for spi_ram_arbiter (ADDR_SIZE=8, TIMEOUT=4).
module tb_spi_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [15:0] addr, wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        rd_valid, rd_err;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  int n_vec = 0;
  int n_bad = 0;

  spi_ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .rd_valid(rd_valid), .rd_err(rd_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full command/response output bundle in one call
  task automatic check_out(input string tag, input logic [9:0] din, input logic rxv,
                           input logic [1:0] a, input logic rv, input logic re);
    check({tag, ".ram_din"},  16'(ram_din), 16'(din));
    check({tag, ".rx_valid"}, 16'(ram_rx_valid), 16'(rxv));
    check({tag, ".ack"},      16'(ack), 16'(a));
    check({tag, ".rd_valid"}, 16'(rd_valid), 16'(rv));
    check({tag, ".rd_err"},   16'(rd_err), 16'(re));
  endtask

  task automatic do_reset();
    req = 2'b00; we = 2'b00; ram_tx_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    addr = 16'h0000; wdata = 16'h0000; ram_dout = 8'h00;
    do_reset();
    check_out("reset", 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);
    check("reset.rdata", 16'(rdata), 16'h0000);

    // Write 0xC5 to 0x3A from requester 0
    req = 2'b01; we = 2'b01; addr = 16'h003A; wdata = 16'h00C5;
    tick();
    check_out("wr.c1", 10'h03A, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check_out("wr.c2", 10'h1C5, 1'b1, 2'b01, 1'b0, 1'b0);
    req = 2'b00;
    tick();
    check_out("wr.c3", 10'h1C5, 1'b0, 2'b00, 1'b0, 1'b0);

    // Read back 0x3A from requester 1; RAM answers in cycle 3
    req = 2'b10; we = 2'b00; addr = 16'h3A00;
    tick();
    check_out("rd.c1", 10'h23A, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check_out("rd.c2", 10'h300, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check_out("rd.c3", 10'h300, 1'b0, 2'b00, 1'b0, 1'b0);
    ram_tx_valid = 1'b1; ram_dout = 8'hC5;
    tick();
    check_out("rd.c4", 10'h300, 1'b0, 2'b10, 1'b1, 1'b0);
    check("rd.c4.rdata", 16'(rdata), 16'h00C5);
    ram_tx_valid = 1'b0; ram_dout = 8'h00; req = 2'b00;
    tick();
    check_out("rd.c5", 10'h300, 1'b0, 2'b00, 1'b0, 1'b0);

    // Read with no RAM response: error after 4 cycles in RD_WAIT
    req = 2'b01; we = 2'b00; addr = 16'h0055;
    tick();
    check("to.c1.ram_din", 16'(ram_din), 16'h0255);
    tick();
    check("to.c2.ram_din", 16'(ram_din), 16'h0300);
    for (int c = 3; c <= 6; c++) begin
      tick();
      check_out($sformatf("to.c%0d", c), 10'h300, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    tick();
    check_out("to.c7", 10'h300, 1'b0, 2'b01, 1'b0, 1'b1);
    check("to.c7.rdata", 16'(rdata), 16'h0000);
    req = 2'b00;
    tick();
    check("to.c8.ack", 16'(ack), 16'h0000);

    // Simultaneous held requests from reset alternate 0,1,0,1
    do_reset();
    req = 2'b11; we = 2'b11; addr = 16'h2211; wdata = 16'hBBAA;
    tick();
    check("rr.first.ram_din", 16'(ram_din), 16'h0011);
    tick();
    check("rr.ack0", 16'(ack), 16'h0001);
    tick();
    tick();
    check("rr.second.ram_din", 16'(ram_din), 16'h0022);
    tick();
    check("rr.ack1", 16'(ack), 16'h0002);
    check("rr.ack1.ram_din", 16'(ram_din), 16'h01BB);
    tick(); tick(); tick();
    check("rr.ack2", 16'(ack), 16'h0001);
    tick(); tick(); tick();
    check("rr.ack3", 16'(ack), 16'h0002);
    req = 2'b00;

    // Reset during RD_CMD aborts with no ack
    do_reset();
    req = 2'b10; we = 2'b00; addr = 16'h7700;
    tick();
    check("rst.c1.ram_din", 16'(ram_din), 16'h0277);
    tick();
    check("rst.c2.ram_din", 16'(ram_din), 16'h0300);
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0;
    check_out("rst.c3", 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);
    ram_tx_valid = 1'b1; ram_dout = 8'h99;
    tick();
    check_out("rst.c4", 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);
    ram_tx_valid = 1'b0; ram_dout = 8'h00;

    // Two writes to 0x10: address command skipped on the second when cached
    do_reset();
    req = 2'b01; we = 2'b01; addr = 16'h0010; wdata = 16'h0001;
    tick();
    check("c.w1.c1.ram_din", 16'(ram_din), 16'h0010);
    tick();
    check("c.w1.c2.ack", 16'(ack), 16'h0001);
    req = 2'b00;
    tick();
    req = 2'b01; wdata = 16'h0002;
    tick();
`ifdef RAM_ADDR_CACHE_EN
    check_out("c.w2.c1", 10'h102, 1'b1, 2'b01, 1'b0, 1'b0);
`else
    check_out("c.w2.c1", 10'h010, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check_out("c.w2.c2", 10'h102, 1'b1, 2'b01, 1'b0, 1'b0);
`endif
    req = 2'b00;
    tick();
    check("c.end.ack", 16'(ack), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
